// File: rtl/phase_sequencer.sv
// phase_sequencer: steps each instruction through the F,R,X,M,W phases and registers branch decision, halt and retire count.
// Ports: clk, n_rst (async active-low); i_ready/d_ready memory handshakes; mem_op, hlt_req, br_cond, br_target decoder inputs;
// phase_f..phase_w one-hot strobes; ct_taken/ct_pc registered branch; halted; instret retired count.
// Build option: define MEM_WAIT_EN to enable the FW fetch-wait state and data-memory waits in M.
module phase_sequencer (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        i_ready,
    input  logic        d_ready,
    input  logic        mem_op,
    input  logic        hlt_req,
    input  logic        br_cond,
    input  logic [31:0] br_target,
    output logic        phase_f,
    output logic        phase_r,
    output logic        phase_x,
    output logic        phase_m,
    output logic        phase_w,
    output logic        ct_taken,
    output logic [31:0] ct_pc,
    output logic        halted,
    output logic [31:0] instret
);
    typedef enum logic [2:0] {S_F, S_FW, S_R, S_X, S_M, S_W, S_HALT} state_t;
    state_t state, nxt;
    logic   hlt_flag;
`ifndef MEM_WAIT_EN
    // Handshakes are meaningless without wait states.
    logic unused_inputs;
    assign unused_inputs = i_ready ^ d_ready ^ mem_op;
`endif
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= S_F;
            hlt_flag <= 1'b0;
            ct_taken <= 1'b0;
            ct_pc    <= '0;
            instret  <= '0;
        end else begin
            state <= nxt;
            if (state == S_R && hlt_req) hlt_flag <= 1'b1;
            if (state == S_X) begin
                ct_taken <= br_cond;
                ct_pc    <= br_target;
            end else if (nxt == S_F) begin
                // Branch decision is dead once the next fetch starts.
                ct_taken <= 1'b0;
                ct_pc    <= '0;
            end
            if (state == S_W) instret <= instret + 32'd1;
        end
    end
    always_comb begin
        nxt = state;
        case (state)
`ifdef MEM_WAIT_EN
            S_F:  nxt = i_ready ? S_R : S_FW;
            S_FW: nxt = i_ready ? S_R : S_FW;
            S_M:  nxt = (!mem_op || d_ready) ? S_W : S_M;
`else
            S_F:  nxt = S_R;
            S_M:  nxt = S_W;
`endif
            S_R:    nxt = S_X;
            S_X:    nxt = S_M;
            S_W:    nxt = hlt_flag ? S_HALT : S_F;
            S_HALT: nxt = S_HALT;
            default: nxt = S_F;
        endcase
    end
    assign phase_f = state == S_F;
    assign phase_r = state == S_R;
    assign phase_x = state == S_X;
    assign phase_m = state == S_M;
    assign phase_w = state == S_W;
    assign halted  = state == S_HALT;
endmodule
